io_port_sequencer: RTL and testbench

Drives an 8-bit user GPIO bank through a fixed bring-up pattern so the board-level IO self-test can confirm every pad of the user project. It sits in the user project area next to the rapcore logic and owns `mprj_io[7:0]`. The block steps the bank through 0x01…0x0A, then 0xFF, then 0x00, with a programmable dwell per value, and then flags completion.

---
 rtl/io_port_sequencer_if.sv | 22 ++
 rtl/io_port_sequencer.sv | 115 +++++++++++
 tb/tb_io_port_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/io_port_sequencer_if.sv
// Control and pad signals of the GPIO bring-up sequencer.
// The sequencer connects through the slave modport and its driver through the master modport.
interface io_port_sequencer_if;
  logic       start;
  logic       hold;
  logic [7:0] io_out;
  logic [7:0] io_oeb;
  logic [3:0] step_idx;
  logic       step_strobe;
  logic       busy;
  logic       done;

  modport slave (
    input  start, hold,
    output io_out, io_oeb, step_idx, step_strobe, busy, done
  );

  modport master (
    output start, hold,
    input  io_out, io_oeb, step_idx, step_strobe, busy, done
  );
endinterface

// File: rtl/io_port_sequencer.sv
// Steps the user GPIO bank through 0x01..0x0A, 0xFF, 0x00, holding each value for DWELL cycles.
//
// state | meaning
// IDLE  | pads released (oeb=0xFF), waiting for start
// RUN   | driving the pattern, dwell counter active
// DONE  | sequence complete, pads driven low, start re-runs
module io_port_sequencer #(
  parameter int unsigned DWELL = 16
) (
  input  logic                clock,
  input  logic                resetb,
  io_port_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
  localparam logic [3:0]  LAST_IDX   = 4'd11;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  io_out_q, io_out_d;
  logic [7:0]  io_oeb_q, io_oeb_d;
  logic        strobe_q, strobe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  function automatic logic [7:0] pattern(input logic [3:0] idx);
    if (idx < 4'd10) begin
      return {4'h0, idx + 4'd1};
    end else if (idx == 4'd10) begin
      return 8'hFF;
    end else begin
      return 8'h00;
    end
  endfunction

  // Next-state and next-output logic; the strobe defaults low so it is a single-cycle pulse.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    io_out_d = io_out_q;
    io_oeb_d = io_oeb_q;
    strobe_d = 1'b0;
    busy_d   = busy_q;
    done_d   = done_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = RUN;
          cnt_d    = 16'd0;
          idx_d    = 4'd0;
          io_out_d = pattern(4'd0);
          io_oeb_d = 8'h00;
          strobe_d = 1'b1;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end
      RUN: begin
        if (!bus.hold) begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d = 16'd0;
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              idx_d    = idx_q + 4'd1;
              io_out_d = pattern(idx_q + 4'd1);
              strobe_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset releases the pads and clears every flag at once.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q  <= IDLE;
      cnt_q    <= 16'd0;
      idx_q    <= 4'd0;
      io_out_q <= 8'h00;
      io_oeb_q <= 8'hFF;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      io_out_q <= io_out_d;
      io_oeb_q <= io_oeb_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.io_out      = io_out_q;
  assign bus.io_oeb      = io_oeb_q;
  assign bus.step_idx    = idx_q;
  assign bus.step_strobe = strobe_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_io_port_sequencer.sv
// Directed bench for io_port_sequencer: DWELL=4 instance (a) and DWELL=1 instance (b).
module tb_io_port_sequencer;

  logic clock  = 1'b0;
  logic resetb = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  io_port_sequencer_if bus_a ();
  io_port_sequencer_if bus_b ();

  io_port_sequencer #(.DWELL(4)) dut_a (.clock(clock), .resetb(resetb), .bus(bus_a));
  io_port_sequencer #(.DWELL(1)) dut_b (.clock(clock), .resetb(resetb), .bus(bus_b));

  always #5 clock = ~clock;

  logic [7:0] exp_tab [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                               8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int a_idx(input int c, input int hold_from, input int hold_len);
    int ce;
    ce = c;
    if (c > hold_from) ce = (c - hold_len > hold_from) ? c - hold_len : hold_from;
    return ce / 4;
  endfunction

  // Runs one full sequence on instance a, starting with a start pulse.
  task automatic run_a(input string name, input int hold_from, input int hold_len,
                       input int mid_start_at, input int total);
    int strobes;
    int idx;
    int prev;
    strobes = 0;
    prev = -1;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int c = 0; c < total; c++) begin
      idx = a_idx(c, hold_from, hold_len);
      chk({name, "_io_out"}, bus_a.io_out, exp_tab[idx]);
      chk({name, "_step_idx"}, bus_a.step_idx, idx);
      chk({name, "_strobe"}, bus_a.step_strobe, (idx != prev));
      chk({name, "_oeb"}, bus_a.io_oeb, 8'h00);
      chk({name, "_busy"}, bus_a.busy, 1);
      chk({name, "_done"}, bus_a.done, 0);
      if (bus_a.step_strobe) strobes++;
      prev = idx;
      bus_a.hold  = (hold_len > 0) && (c >= hold_from) && (c < hold_from + hold_len);
      bus_a.start = (c == mid_start_at);
      tick();
    end
    bus_a.hold  = 1'b0;
    bus_a.start = 1'b0;
    chk({name, "_end_done"}, bus_a.done, 1);
    chk({name, "_end_busy"}, bus_a.busy, 0);
    chk({name, "_end_io_out"}, bus_a.io_out, 8'h00);
    chk({name, "_end_oeb"}, bus_a.io_oeb, 8'h00);
    chk({name, "_end_strobe"}, bus_a.step_strobe, 0);
    chk({name, "_strobe_count"}, strobes, 12);
    tick();
    chk({name, "_done_held"}, bus_a.done, 1);
    chk({name, "_io_out_held"}, bus_a.io_out, 8'h00);
  endtask

  initial begin
    bus_a.start = 1'b0;
    bus_a.hold  = 1'b0;
    bus_b.start = 1'b0;
    bus_b.hold  = 1'b0;
    #12;
    chk("rst_io_out", bus_a.io_out, 8'h00);
    chk("rst_oeb", bus_a.io_oeb, 8'hFF);
    chk("rst_idx", bus_a.step_idx, 0);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_done", bus_a.done, 0);
    chk("rst_strobe", bus_a.step_strobe, 0);
    tick();
    resetb = 1'b1;
    tick();
    chk("idle_oeb", bus_a.io_oeb, 8'hFF);
    chk("idle_io_out", bus_a.io_out, 8'h00);

    // Plain run with a start pulse in the middle that must be ignored.
    run_a("run1", 0, 0, 20, 48);

    // Restart from DONE with hold for 5 cycles while 0x05 is shown.
    run_a("hold", 16, 5, -1, 53);

    // DWELL=1: value changes every cycle, done after 12 cycles.
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      chk("d1_io_out", bus_b.io_out, exp_tab[c]);
      chk("d1_strobe", bus_b.step_strobe, 1);
      chk("d1_busy", bus_b.busy, 1);
      tick();
    end
    chk("d1_done", bus_b.done, 1);
    chk("d1_busy_end", bus_b.busy, 0);
    chk("d1_strobe_end", bus_b.step_strobe, 0);

    // Asynchronous reset while 0xFF is showing.
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int c = 0; c < 41; c++) tick();
    chk("pre_rst_io_out", bus_a.io_out, 8'hFF);
    chk("pre_rst_busy", bus_a.busy, 1);
    #2;
    resetb = 1'b0;
    #1;
    chk("arst_io_out", bus_a.io_out, 8'h00);
    chk("arst_oeb", bus_a.io_oeb, 8'hFF);
    chk("arst_busy", bus_a.busy, 0);
    chk("arst_done", bus_a.done, 0);
    chk("arst_strobe", bus_a.step_strobe, 0);
    chk("arst_idx", bus_a.step_idx, 0);
    tick();
    chk("arst_hold_strobe", bus_a.step_strobe, 0);
    resetb = 1'b1;
    run_a("post_rst", 0, 0, -1, 48);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
